// File: rtl/cmp_sar_pkg.sv
// rtl/cmp_sar_pkg.sv - shared types and defaults for the SAR search engine
// Contents: FSM state enum (IDLE/WAIT/DONE), default WIDTH and CMP_LAT,
//           flag one-hot helper used at each decision edge.
package cmp_sar_pkg;

  localparam int unsigned CMP_SAR_WIDTH   = 8;
  localparam int unsigned CMP_SAR_CMP_LAT = 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } cmp_sar_state_e;

  // Exactly one of gt/lt/eq must be high for a comparator answer to be trusted.
  function automatic logic flags_onehot(input logic gt, input logic lt, input logic eq);
    return (gt & ~lt & ~eq) | (~gt & lt & ~eq) | (~gt & ~lt & eq);
  endfunction

endpackage

// File: rtl/cmp_sar_search_if.sv
// rtl/cmp_sar_search_if.sv - control, probe and result bundle of the SAR search engine
// Signals: start (request), probe (to comparator b), a_gt_b/a_lt_b/a_eq_b
//          (comparator flags), busy, done, result, err.
// Modports: master = search engine, slave = surrounding logic / comparator side.
interface cmp_sar_search_if
  import cmp_sar_pkg::*;
#(
  parameter int unsigned WIDTH = CMP_SAR_WIDTH
);

  logic             start;
  logic [WIDTH-1:0] probe;
  logic             a_gt_b;
  logic             a_lt_b;
  logic             a_eq_b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             err;

  modport master (
    input  start, a_gt_b, a_lt_b, a_eq_b,
    output probe, busy, done, result, err
  );

  modport slave (
    output start, a_gt_b, a_lt_b, a_eq_b,
    input  probe, busy, done, result, err
  );

endinterface

// File: rtl/cmp_sar_search.sv
// rtl/cmp_sar_search.sv - successive-approximation search against a registered comparator
// Ports: clk, rst (sync, active-high), bus (cmp_sar_search_if.master).
// Build option: CMP_SAR_EARLY_EXIT_EN - an eq answer ends the search at once
//               with result = current probe; otherwise all WIDTH steps always run.
module cmp_sar_search
  import cmp_sar_pkg::*;
#(
  parameter int unsigned WIDTH   = CMP_SAR_WIDTH,
  parameter int unsigned CMP_LAT = CMP_SAR_CMP_LAT
) (
  input  logic              clk,
  input  logic              rst,
  cmp_sar_search_if.master  bus
);

  localparam int unsigned IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int unsigned CW = $clog2(CMP_LAT + 1);

  cmp_sar_state_e   state_q, state_d;
  logic [WIDTH-1:0] probe_q;
  logic [IW-1:0]    idx_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] result_q;
  logic             err_q;

  logic             flags_ok;
  logic             sample;
  logic             last_bit;
  logic             early;
  logic             finish;
  logic [WIDTH-1:0] bit_mask;
  logic [WIDTH-1:0] decided;
  logic             busy_c;
  logic             done_c;

  // Decision-edge datapath. The probe already carries bit idx set, so a gt/eq
  // answer keeps it as-is and only lt needs the bit cleared.
  always_comb begin
    flags_ok = flags_onehot(bus.a_gt_b, bus.a_lt_b, bus.a_eq_b);
    sample   = (state_q == WAIT) && (cnt_q == '0);
    last_bit = (idx_q == '0);
    bit_mask = WIDTH'(1) << idx_q;
    decided  = bus.a_lt_b ? (probe_q & ~bit_mask) : probe_q;
`ifdef CMP_SAR_EARLY_EXIT_EN
    early    = bus.a_eq_b;
`else
    early    = 1'b0;
`endif
    finish   = sample && (!flags_ok || early || last_bit);
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.start) state_d = WAIT;
      WAIT:    if (finish)    state_d = DONE;
      DONE:                   state_d = IDLE;
      default:                state_d = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    busy_c = (state_q == WAIT);
    done_c = (state_q == DONE);
  end

  // Search datapath: probe, bit index, latency counter, result and error.
  always_ff @(posedge clk) begin
    if (rst) begin
      probe_q  <= '0;
      idx_q    <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      err_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            probe_q  <= WIDTH'(1) << (WIDTH - 1);
            idx_q    <= IW'(WIDTH - 1);
            cnt_q    <= CW'(CMP_LAT);
            result_q <= '0;
            err_q    <= 1'b0;
          end
        end
        WAIT: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - CW'(1);
          end else if (!flags_ok) begin
            err_q    <= 1'b1;
            result_q <= '0;
          end else if (early) begin
            result_q <= probe_q;
          end else if (last_bit) begin
            result_q <= decided;
          end else begin
            // Next trial: decided upper bits plus the next lower bit set.
            probe_q <= decided | (bit_mask >> 1);
            idx_q   <= idx_q - IW'(1);
            cnt_q   <= CW'(CMP_LAT);
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.probe  = probe_q;
  assign bus.busy   = busy_c;
  assign bus.done   = done_c;
  assign bus.result = result_q;
  assign bus.err    = err_q;

endmodule

// File: tb/tb_cmp_sar_search.sv
// tb/tb_cmp_sar_search.sv - directed self-checking bench for cmp_sar_search
// Models a registered one-cycle 8-bit comparator with a flag-kill override.
// Build option: CMP_SAR_EARLY_EXIT_EN selects the early-exit expectations.
module tb_cmp_sar_search;

  logic       clk;
  logic       rst;
  logic [7:0] target;
  logic       kill;
  logic       gt_q, lt_q, eq_q;

  int vectors;
  int miscompares;

  int probes [0:15];
  int nprobe;
  int lat;
  int ndone;
  logic busy_ok;

`ifdef CMP_SAR_EARLY_EXIT_EN
  localparam int LAT_150 = 14;  // eq on the 7th trial: 7 * 2 cycles
  localparam int N_150   = 7;
  localparam int LAT_128 = 2;
  localparam int LAT_60  = 12;  // 128,64,32,48,56,60 -> eq on 6th trial
  localparam int LAT_255 = 16;  // eq only on the 8th trial
`else
  localparam int LAT_150 = 16;
  localparam int N_150   = 8;
  localparam int LAT_128 = 16;
  localparam int LAT_60  = 16;
  localparam int LAT_255 = 16;
`endif

  int exp_150 [0:7] = '{128, 192, 160, 144, 152, 148, 150, 151};

  cmp_sar_search_if #(.WIDTH(8)) bus ();

  cmp_sar_search #(.WIDTH(8), .CMP_LAT(1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_ff @(posedge clk) begin
    gt_q <= target > bus.probe;
    lt_q <= target < bus.probe;
    eq_q <= target == bus.probe;
  end

  assign bus.a_gt_b = gt_q & ~kill;
  assign bus.a_lt_b = lt_q & ~kill;
  assign bus.a_eq_b = eq_q & ~kill;

  task automatic chk(input string tag, input int got, input int exp);
    vectors++;
    if (got != exp) begin
      miscompares++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic run_search(input int tgt, input int exp_res, input int exp_lat,
                            input int exp_err, input string tag);
    target = 8'(tgt);
    @(negedge clk) bus.start = 1'b1;
    @(posedge clk) #1 bus.start = 1'b0;
    chk({tag, "_busy_on_accept"}, int'(bus.busy), 1);
    chk({tag, "_err_clr_on_accept"}, int'(bus.err), 0);
    probes[0] = int'(bus.probe);
    nprobe    = 1;
    lat       = 0;
    ndone     = 0;
    busy_ok   = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk) #1;
      if (bus.done) begin
        if (ndone == 0) lat = k;
        ndone++;
      end else if (ndone == 0 && !bus.busy) begin
        busy_ok = 1'b0;
      end
      if (bus.busy && int'(bus.probe) != probes[nprobe-1] && nprobe < 16) begin
        probes[nprobe] = int'(bus.probe);
        nprobe++;
      end
    end
    chk({tag, "_latency"}, lat, exp_lat);
    chk({tag, "_done_pulses"}, ndone, 1);
    chk({tag, "_busy_held"}, int'(busy_ok), 1);
    chk({tag, "_result"}, int'(bus.result), exp_res);
    chk({tag, "_err"}, int'(bus.err), exp_err);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst         = 1'b1;
    kill        = 1'b0;
    target      = 8'd0;
    bus.start   = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_probe", int'(bus.probe), 0);
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_done", int'(bus.done), 0);
    chk("rst_result", int'(bus.result), 0);
    chk("rst_err", int'(bus.err), 0);
    rst = 1'b0;
    @(posedge clk) #1;

    // 150: full probe trace
    run_search(150, 150, LAT_150, 0, "t150");
    chk("t150_nprobe", nprobe, N_150);
    for (int i = 0; i < N_150; i++) chk($sformatf("t150_probe%0d", i), probes[i], exp_150[i]);

    run_search(0, 0, 16, 0, "t0");
    chk("t0_last_probe", probes[nprobe-1], 1);
    run_search(255, 255, LAT_255, 0, "t255");
    chk("t255_last_probe", probes[nprobe-1], 255);
    run_search(128, 128, LAT_128, 0, "t128");

    // Dead comparator: no flags at the first decision edge
    kill = 1'b1;
    run_search(77, 0, 2, 1, "kill");
    kill = 1'b0;
    repeat (3) @(posedge clk);
    #1 chk("kill_err_held", int'(bus.err), 1);
    run_search(150, 150, LAT_150, 0, "after_kill");

    // Reset in the middle of a search
    target = 8'd150;
    @(negedge clk) bus.start = 1'b1;
    @(posedge clk) #1 bus.start = 1'b0;
    repeat (6) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk) #1;
    chk("midrst_probe", int'(bus.probe), 0);
    chk("midrst_busy", int'(bus.busy), 0);
    chk("midrst_done", int'(bus.done), 0);
    chk("midrst_result", int'(bus.result), 0);
    chk("midrst_err", int'(bus.err), 0);
    rst   = 1'b0;
    ndone = 0;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk) #1;
      if (bus.done) ndone++;
    end
    chk("midrst_no_done", ndone, 0);
    run_search(60, 60, LAT_60, 0, "t60");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
